// File: rtl/iso_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iso_alu_pkg
//  Description : Shared op-select codes and FSM state type for iso_alu_hs.
//  Revision    : 1.0  initial release
// ============================================================================
package iso_alu_pkg;

    // One-hot operation select codes, sel[3:0] = {mul, add, div, sub}
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0001;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/iso_alu_divider.sv
`default_nettype none
// ============================================================================
//  Module      : iso_alu_divider
//  Description : Restoring unsigned divider, one quotient bit per cycle.
//                start loads the operands; WIDTH iterations follow. done is
//                high during the final iteration, and quotient/remainder then
//                show the values that iteration produces, so the consumer
//                can capture the result on the same edge. WIDTH >= 2.
//  Revision    : 1.0  initial release
// ============================================================================
module iso_alu_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvs;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_diff;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;

    // One restoring step: shift next dividend bit into the partial remainder
    // and subtract the divisor if it fits. The true difference is below the
    // divisor, so its low WIDTH bits are exact.
    always_comb begin
        w_shift   = {r_rem, r_quo[WIDTH-1]};
        w_fits    = (w_shift >= {1'b0, r_dvs});
        w_diff    = w_shift[WIDTH-1:0] - r_dvs;
        w_rem_nxt = w_fits ? w_diff : w_shift[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};
    end

    // Iteration state: load on start, then step until the count runs out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_quo  <= dividend;
            r_rem  <= '0;
            r_dvs  <= divisor;
            r_cnt  <= c_CNT_W'(WIDTH);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (r_cnt == c_CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_busy && (r_cnt == c_CNT_W'(1));
    assign quotient  = w_quo_nxt;
    assign remainder = w_rem_nxt;

endmodule
`default_nettype wire

// File: rtl/iso_alu_hs.sv
`default_nettype none
// ============================================================================
//  Module      : iso_alu_hs
//  Description : Operand-isolated 4-function ALU (mul/add/div/sub) with
//                valid/ready handshakes on input and output, one operation
//                in flight. Each unit owns its operand registers, which load
//                only when that unit is selected. Division is iterative.
//  Revision    : 1.0  initial release
// ============================================================================
module iso_alu_hs
    import iso_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               err
);

    state_t             r_state;
    logic [3:0]         r_sel;
    logic [WIDTH-1:0]   r_mul_a, r_mul_b;
    logic [WIDTH-1:0]   r_add_a, r_add_b;
    logic [WIDTH-1:0]   r_div_a, r_div_b;
    logic [WIDTH-1:0]   r_sub_a, r_sub_b;
    logic               r_div_start;
    logic [2*WIDTH-1:0] r_out;
    logic               r_out_valid;
    logic               r_err;

    logic               w_accept;
    logic               w_div_go;
    logic [2*WIDTH-1:0] w_mul;
    logic [2*WIDTH-1:0] w_add;
    logic [2*WIDTH-1:0] w_sub;
    logic [2*WIDTH-1:0] w_exec_out;
    logic               w_exec_err;
    logic               w_div_busy;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_div_rem;

    // Ready in IDLE, or in DONE when the held result retires this cycle
    assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept = in_valid && in_ready;
    // Only a real division goes through the iterative unit; b=0 takes EXEC
    assign w_div_go = (sel == OP_DIV) && (b != '0);

    // Operand capture: only the selected unit's registers load, the rest stay frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_add_a <= '0;
            r_add_b <= '0;
            r_div_a <= '0;
            r_div_b <= '0;
            r_sub_a <= '0;
            r_sub_b <= '0;
        end else if (w_accept) begin
            r_sel <= sel;
            case (sel)
                OP_MUL: begin
                    r_mul_a <= a;
                    r_mul_b <= b;
                end
                OP_ADD: begin
                    r_add_a <= a;
                    r_add_b <= b;
                end
                OP_DIV: begin
                    r_div_a <= a;
                    r_div_b <= b;
                end
                OP_SUB: begin
                    r_sub_a <= a;
                    r_sub_b <= b;
                end
                default: ;
            endcase
        end
    end

    // Single-cycle units, each fed only by its own isolated operands
    always_comb begin
        w_mul = {{WIDTH{1'b0}}, r_mul_a} * {{WIDTH{1'b0}}, r_mul_b};
        w_add = {{WIDTH{1'b0}}, r_add_a} + {{WIDTH{1'b0}}, r_add_b};
        w_sub = {{WIDTH{1'b0}}, r_sub_a} - {{WIDTH{1'b0}}, r_sub_b};
    end

    // EXEC result mux; anything not one-hot yields zero with err set.
    // The only division reaching EXEC is the divide-by-zero case.
    always_comb begin
        w_exec_out = '0;
        w_exec_err = 1'b1;
        case (r_sel)
            OP_MUL: begin
                w_exec_out = w_mul;
                w_exec_err = 1'b0;
            end
            OP_ADD: begin
                w_exec_out = w_add;
                w_exec_err = 1'b0;
            end
            OP_SUB: begin
                w_exec_out = w_sub;
                w_exec_err = 1'b0;
            end
            OP_DIV: begin
                w_exec_out = {r_div_a, {WIDTH{1'b1}}};
                w_exec_err = 1'b1;
            end
            default: ;
        endcase
    end

    iso_alu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (r_div_start),
        .dividend  (r_div_a),
        .divisor   (r_div_b),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

    // Control FSM with registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_div_start <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= w_div_go ? ST_DIV : ST_EXEC;
                        r_div_start <= w_div_go;
                    end
                end
                ST_EXEC: begin
                    r_out       <= w_exec_out;
                    r_err       <= w_exec_err;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DIV: begin
                    if (w_div_busy && w_div_done) begin
                        r_out       <= {w_div_rem, w_div_quo};
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_state     <= w_div_go ? ST_DIV : ST_EXEC;
                            r_div_start <= w_div_go;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_iso_alu_hs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iso_alu_hs
//  Description : Scoreboard bench for iso_alu_hs (WIDTH=4). The driver pushes
//                hand-computed expectations; a monitor pops them whenever a
//                new result appears.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_iso_alu_hs;
    import iso_alu_pkg::*;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [3:0]     sel = '0;
    logic           in_ready;
    logic           out_valid;
    logic           err;
    logic [2*W-1:0] out;

    always #5 clk = ~clk;

    iso_alu_hs #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .err       (err)
    );

    typedef struct {
        logic [7:0] out;
        logic       err;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: on each new result pop the expectation; while held, check stability
    initial begin : monitor
        logic prev;
        logic have;
        exp_t cur;
        prev = 1'b0;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev) begin
                if (sb.size() == 0) begin
                    n_total++;
                    have = 1'b0;
                    $display("FAIL unexpected_result: got out=%0h err=%0b, expected no result", out, err);
                end else begin
                    cur  = sb.pop_front();
                    have = 1'b1;
                    check("result_out", 32'(out), 32'(cur.out));
                    check("result_err", 32'(err), 32'(cur.err));
                    check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                end
            end else if (out_valid && have) begin
                check("hold_out", 32'(out), 32'(cur.out));
                check("hold_err", 32'(err), 32'(cur.err));
            end
            prev = out_valid;
        end
    end

    // Present one op starting at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [3:0] s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [7:0] eo, input logic ee, input int el, input bit push);
        int   tries;
        bit   ok;
        exp_t e;
        tries = 0;
        ok    = 1'b0;
        sel = s; a = ia; b = ib; in_valid = 1'b1;
        while (!ok && tries < 50) begin
            #1;
            if (in_ready) ok = 1'b1;
            else begin
                tries++;
                @(negedge clk);
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready=0, expected 1 within 50 cycles");
            in_valid = 1'b0;
        end else begin
            e.out = eo; e.err = ee; e.lat = el; e.acc = cyc + 1;
            @(posedge clk);
            if (push) sb.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Wait until every expected result has appeared and retired
    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || out_valid) begin
            n_total++;
            $display("FAIL drain_timeout: pending=%0d out_valid=%0b, expected 0/0", sb.size(), out_valid);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin : driver
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out", 32'(out), 32'h00);
        check("reset_err", 32'(err), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // T1 mul
        issue(OP_MUL, 4'd15, 4'd15, 8'hE1, 1'b0, 1, 1'b1);
        drain();
        check("iso_mul_a", 32'(dut.r_mul_a), 32'd15);
        check("iso_mul_b", 32'(dut.r_mul_b), 32'd15);

        // T2 sub then add; other units' operands must stay frozen
        issue(OP_SUB, 4'd3, 4'd5, 8'hFE, 1'b0, 1, 1'b1);
        drain();
        issue(OP_ADD, 4'd15, 4'd15, 8'h1E, 1'b0, 1, 1'b1);
        drain();
        check("iso_mul_a_after_add", 32'(dut.r_mul_a), 32'd15);
        check("iso_mul_b_after_add", 32'(dut.r_mul_b), 32'd15);
        check("iso_sub_a_after_add", 32'(dut.r_sub_a), 32'd3);
        check("iso_sub_b_after_add", 32'(dut.r_sub_b), 32'd5);
        check("iso_div_a_after_add", 32'(dut.r_div_a), 32'd0);
        check("iso_div_b_after_add", 32'(dut.r_div_b), 32'd0);

        // T3 div 13/4: q=3 r=1; offered ops during DIV must be refused
        issue(OP_DIV, 4'd13, 4'd4, 8'h13, 1'b0, 5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            sel = OP_ADD; a = 4'd1; b = 4'd1;
            in_valid = (i < 4);
            #1;
            check("div_in_ready_low", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();
        check("iso_add_a_after_div", 32'(dut.r_add_a), 32'd15);
        check("iso_div_b_after_div", 32'(dut.r_div_b), 32'd4);

        // Divide by zero: quotient all ones, remainder = a
        issue(OP_DIV, 4'd9, 4'd0, 8'h9F, 1'b1, 1, 1'b1);
        drain();

        // T4 illegal selects
        issue(4'b1100, 4'd5, 4'd6, 8'h00, 1'b1, 1, 1'b1);
        drain();
        issue(4'b0000, 4'd7, 4'd3, 8'h00, 1'b1, 1, 1'b1);
        drain();

        // Reset during division: leave a nonzero result first
        issue(OP_MUL, 4'd2, 4'd3, 8'h06, 1'b0, 1, 1'b1);
        drain();
        issue(OP_DIV, 4'd13, 4'd4, 8'h00, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out", 32'(out), 32'h00);
        check("abort_err", 32'(err), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (10) @(negedge clk);

        // T5 backpressure then same-cycle retire + accept
        out_ready = 1'b0;
        issue(OP_ADD, 4'd7, 4'd8, 8'h0F, 1'b0, 1, 1'b1);
        n = 0;
        while (!out_valid && n < 15) begin
            @(negedge clk);
            n++;
        end
        check("bp_result_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_follows", 32'(in_ready), 32'd1);
        issue(OP_ADD, 4'd1, 4'd2, 8'h03, 1'b0, 1, 1'b1);
        drain();

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
